sm_arbiter: RTL and testbench
=============================

# sm_arbiter

Round-robin controller that shares one 16x16 sequential multiplier (`SM`) among `NUM_REQ` requesters. Each requester hands over an operand pair with a valid/ready handshake. The block launches the multiplier, waits for completion, and returns the 32-bit product tagged with the requester ID on a shared response port. A watchdog covers a multiplier that never completes. It sits between the requesting datapaths and the single `SM` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand width; product is 2*WIDTH.
- `TIMEOUT`, default 64: cycles waited for `sm_ready` before an error response.
- `clk` input 1: the single clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester operand pair valid.
- `req_ready` output NUM_REQ: per-requester accept, one-hot or zero.
- `req_a` input NUM_REQ*WIDTH: packed multiplicands, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` input NUM_REQ*WIDTH: packed multipliers, same packing.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: response consumer accept.
- `resp_id` output $clog2(NUM_REQ): requester that issued the operation.
- `resp_product` output 2*WIDTH: product; 0 when `resp_err` is set.
- `resp_err` output 1: watchdog expired.
- `sm_start` output 1: one-cycle start pulse to `SM`.
- `sm_multiplicand` output WIDTH: operand to `SM`, held stable from launch to completion.
- `sm_multiplier` output WIDTH: operand to `SM`, held stable from launch to completion.
- `sm_product` input 2*WIDTH: `SM` result.
- `sm_ready` input 1: `SM` completion flag.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE
  - If any `req_valid` is high, select the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[grant]` combinationally in the same cycle.
  - Capture operands into `sm_multiplicand`/`sm_multiplier` and the grant into `resp_id`.
  - Set `rr_ptr <= grant+1`, wrapping from NUM_REQ-1 to 0.
  - Go to LAUNCH.
- LAUNCH
  - `sm_start`=1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT
  - Counter increments every cycle.
  - If `sm_ready`=1, capture `sm_product` into `resp_product`, set `resp_err`=0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT-1, set `resp_product`=0 and `resp_err`=1, go to RESP.
  - If `sm_ready` and expiry occur in the same cycle, `sm_ready` wins.
- RESP
  - `resp_valid`=1; `resp_id`, `resp_product` and `resp_err` are held stable.
  - Leave on `resp_valid && resp_ready`: return to IDLE.
  - Arbitration happens only in IDLE, so the earliest next accept is the cycle after the response handshake.
- Handshake rules
  - `req_ready` is never high outside IDLE.
  - A request with `req_valid` high and no grant must be held by its requester; the block does not drop it.
  - Round-robin guarantees every continuously valid requester is served within NUM_REQ operations.
- Arithmetic: the product is unsigned, carried unmodified from `SM`; no truncation.
- Reset (asynchronous, any state, including mid-WAIT)
  - State to IDLE, `rr_ptr`=0, counter=0.
  - `req_ready`=0, `sm_start`=0, `resp_valid`=0, `resp_err`=0, `resp_id`=0, `resp_product`=0, `sm_multiplicand`=0, `sm_multiplier`=0.
  - An in-flight operation is abandoned with no response.
  - `SM` shares the same `reset`.

## Timing
- Accept-to-launch is 1 cycle: accept in IDLE at cycle N, `sm_start` at N+1.
- The WAIT test of `sm_ready` begins at N+2. `SM` drops `sm_ready` on the edge that samples `sm_start`, so a stale ready is never seen.
- `resp_valid` rises 1 cycle after `sm_ready` is seen in WAIT.
- Minimum occupancy per operation = 3 + SM latency + response wait cycles.
- Error response: `resp_valid` rises at N+2+TIMEOUT when `sm_ready` never comes.

## Structure
- Package `sm_arb_pkg`:
  - FSM state enum `sm_arb_state_t`.
  - Default constants `SM_ARB_NUM_REQ`, `SM_ARB_WIDTH`, `SM_ARB_TIMEOUT`.
  - `ID_W` = $clog2(NUM_REQ).
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: request vector and pointer. Outputs: one-hot grant, encoded index, any-valid.
  - Reusable for other shared resources.
- Top-level `sm_arbiter` holds the FSM, operand/result registers, pointer and watchdog. `SM` is instantiated outside.

## Test plan
- Single request:
  - Stimulus: requester 0 sends a=0x1234, b=0x0040.
  - Response: `resp_id`=0, `resp_product`=0x00048D00, `resp_err`=0, exactly one `sm_start` pulse.
- All 4 requesters valid continuously, each with a=i+1 and b=3:
  - Grants in order 0,1,2,3,0.
  - Products 3, 6, 9, 12, 3.
- Max operands:
  - Stimulus: requester 2 sends a=0xFFFF, b=0xFFFF.
  - Response: `resp_product`=0xFFFE0001, `resp_id`=2.
- Back-pressure:
  - Stimulus: hold `resp_ready`=0 for 10 cycles with requester 1 pending.
  - Response: the response stays stable, `req_ready` stays 0, requester 1 is accepted the cycle after the handshake.
- Watchdog:
  - Stimulus: a stub `SM` never asserts `sm_ready`.
  - Response: `resp_err`=1 and `resp_product`=0 at accept+2+TIMEOUT; next request proceeds normally.
- Reset mid-WAIT:
  - Stimulus: assert `reset` asynchronously (between clock edges) while in WAIT.
  - Response: all outputs 0 immediately, no response is emitted, and the next grant starts from `rr_ptr`=0.

Source files
------------

// File: rtl/sm_arb_pkg.sv
// ---------------------------------------------------------------------------
// sm_arb_pkg
//   Shared types and default constants for the sequential-multiplier
//   arbiter (sm_arbiter) and its round-robin selector (rr_arbiter).
//   Contents:
//     sm_arb_state_t  : controller FSM state encoding
//     SM_ARB_*        : default parameter values for sm_arbiter
//     ID_W            : requester-id width for the default requester count
//     sm_arb_cnt_w()  : watchdog counter width for a given timeout
// ---------------------------------------------------------------------------
package sm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } sm_arb_state_t;

  localparam int SM_ARB_NUM_REQ = 4;
  localparam int SM_ARB_WIDTH   = 16;
  localparam int SM_ARB_TIMEOUT = 64;

  localparam int ID_W = $clog2(SM_ARB_NUM_REQ);

  // The watchdog only has to count up to timeout-1, so $clog2(timeout)
  // bits are enough; keep at least one bit for degenerate timeouts.
  function automatic int sm_arb_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage : sm_arb_pkg

// File: rtl/sm_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. Picks the first asserted
//   request at or after the pointer position, wrapping around to index 0.
//   Reusable for any shared resource; holds no state of its own, the owner
//   keeps and advances the pointer.
//   Ports:
//     req       [N-1:0]   : request vector
//     ptr       [IDW-1:0] : highest-priority index this cycle (must be < N)
//     grant     [N-1:0]   : one-hot grant, all zero when nothing requests
//     grant_idx [IDW-1:0] : encoded grant index (0 when nothing requests)
//     any_valid           : at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_valid
);

  logic [N-1:0]   hi_mask_s;
  logic [N-1:0]   masked_s;
  logic [N-1:0]   sel_s;
  logic [IDW-1:0] idx_s;

  // Split the requests into the "at or after ptr" half; if that half is
  // empty the search wraps, which is the same as searching the full vector
  // from bit 0. A lowest-index priority encode then finishes the job.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = (IDW'(i) >= ptr);
    end
    masked_s = req & hi_mask_s;
    sel_s    = (|masked_s) ? masked_s : req;
    idx_s    = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = sel_s[i] ? IDW'(i) : idx_s;
    end
  end

  // Drive the encoded and one-hot forms of the selected request.
  always_comb begin
    any_valid = |req;
    grant_idx = idx_s;
    grant     = any_valid ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};
  end

endmodule : rr_arbiter

// File: rtl/sm_arbiter.sv
// ---------------------------------------------------------------------------
// sm_arbiter
//   Shares one sequential multiplier (SM) among NUM_REQ requesters. A
//   request is accepted in IDLE with a round-robin choice, the operands are
//   launched into the SM with a one-cycle start pulse, the controller waits
//   for sm_ready (or watchdog expiry), and the tagged product is offered on
//   a single response port until it is taken.
//   Parameters:
//     NUM_REQ (2..8), WIDTH (operand width), TIMEOUT (cycles waited in WAIT)
//   Ports:
//     clk, reset                  : clock, asynchronous active-high reset
//     req_valid/req_ready         : per-requester handshake (ready is
//                                   one-hot or zero, only ever in IDLE)
//     req_a/req_b                 : packed operands, requester i at
//                                   [i*WIDTH +: WIDTH]
//     resp_valid/resp_ready       : response handshake
//     resp_id/resp_product/resp_err : response payload (product 0 on error)
//     sm_start                    : one-cycle launch pulse to the SM
//     sm_multiplicand/sm_multiplier : SM operands, stable launch..completion
//     sm_product/sm_ready         : SM result and completion flag
// ---------------------------------------------------------------------------
module sm_arbiter
  import sm_arb_pkg::*;
#(
  parameter int NUM_REQ = SM_ARB_NUM_REQ,
  parameter int WIDTH   = SM_ARB_WIDTH,
  parameter int TIMEOUT = SM_ARB_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       resp_err,
  output logic                       sm_start,
  output logic [WIDTH-1:0]           sm_multiplicand,
  output logic [WIDTH-1:0]           sm_multiplier,
  input  logic [2*WIDTH-1:0]         sm_product,
  input  logic                       sm_ready
);

  localparam int ID_BITS = $clog2(NUM_REQ);
  localparam int CNT_W   = sm_arb_cnt_w(TIMEOUT);

  sm_arb_state_t        state_q, state_d;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     wdog_q, wdog_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic                 resp_valid_q, resp_valid_d;

  logic [NUM_REQ-1:0]   grant_oh_s;
  logic [ID_BITS-1:0]   grant_idx_s;
  logic                 any_valid_s;
  logic [WIDTH-1:0]     a_sel_s;
  logic [WIDTH-1:0]     b_sel_s;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_BITS)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_valid_s)
  );

  // Operand mux for the granted requester; the grant is one-hot so an
  // AND-OR structure is sufficient.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel_s = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
      b_sel_s = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
    end
  end

  // Accept is only offered from IDLE. The reset term keeps req_ready low
  // while reset is held, since the state register already reads IDLE then.
  always_comb begin
    if ((state_q == ST_IDLE) && !reset) begin
      req_ready = grant_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and register updates for the accept/launch/wait/respond loop.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    id_d         = id_q;
    product_d    = product_q;
    err_d        = err_q;
    start_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          mcand_d  = a_sel_s;
          mplier_d = b_sel_s;
          id_d     = grant_idx_s;
          rr_ptr_d = (grant_idx_s == ID_BITS'(NUM_REQ - 1)) ? '0
                                                            : grant_idx_s + ID_BITS'(1);
          // Registered start so the pulse coincides exactly with LAUNCH.
          start_d  = 1'b1;
          state_d  = ST_LAUNCH;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + CNT_W'(1);
        // Completion is tested first so it wins over a same-cycle expiry.
        if (sm_ready) begin
          product_d    = sm_product;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          product_d    = '0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d      = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_RESP;
        end
      end
      default: begin
        start_d      = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State, pointer, watchdog and payload registers; reset abandons any
  // in-flight operation without producing a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      wdog_q       <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      id_q         <= '0;
      product_q    <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wdog_q       <= wdog_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      id_q         <= id_d;
      product_q    <= product_d;
      err_q        <= err_d;
      start_q      <= start_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign sm_start        = start_q;
  assign sm_multiplicand = mcand_q;
  assign sm_multiplier   = mplier_q;
  assign resp_valid      = resp_valid_q;
  assign resp_id         = id_q;
  assign resp_product    = product_q;
  assign resp_err        = err_q;

endmodule : sm_arbiter

// File: tb/tb_sm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sm_arbiter
//   Self-checking bench for sm_arbiter with a behavioural multiplier model.
//   Expected responses are pushed when a request is accepted and compared
//   while the response is offered.
// ---------------------------------------------------------------------------
module tb_sm_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [2*WIDTH-1:0] prod;
    logic               err;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     resp_err;
  logic                     sm_start;
  logic [WIDTH-1:0]         sm_multiplicand;
  logic [WIDTH-1:0]         sm_multiplier;
  logic [2*WIDTH-1:0]       sm_product;
  logic                     sm_ready;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t scb[$];
  int   got_ids[$];
  logic [31:0] got_prods[$];
  logic got_errs[$];
  int   acc_ids[$];
  int   model_ptr = 0;
  int   acc_cyc = -100;
  bit   acc_stub = 1'b0;
  int   hs_cyc = -100;
  int   n_start = 0;
  bit   prev_rv = 1'b0;
  bit   stub_mode = 1'b0;

  sm_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_product    (resp_product),
    .resp_err        (resp_err),
    .sm_start        (sm_start),
    .sm_multiplicand (sm_multiplicand),
    .sm_multiplier   (sm_multiplier),
    .sm_product      (sm_product),
    .sm_ready        (sm_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SM: drops ready on the edge that samples start, completes
  // LAT cycles later (never when stubbed); product is junk until completion.
  logic sm_busy;
  int   sm_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sm_busy    <= 1'b0;
      sm_cnt     <= 0;
      sm_ready   <= 1'b0;
      sm_product <= '0;
    end else if (sm_start) begin
      sm_busy    <= 1'b1;
      sm_cnt     <= 0;
      sm_ready   <= 1'b0;
      sm_product <= 32'hDEAD_BEEF;
    end else if (sm_busy) begin
      if (sm_cnt == LAT - 1) begin
        sm_busy    <= 1'b0;
        sm_ready   <= !stub_mode;
        sm_product <= stub_mode ? 32'hBAD0_BAD0
                                : 32'(sm_multiplicand) * 32'(sm_multiplier);
      end else begin
        sm_cnt <= sm_cnt + 1;
      end
    end
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: models round-robin grants, fills the scoreboard on accept,
  // checks timing and payload while a response is offered.
  initial begin
    int e;
    int j;
    exp_t x;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != '0) begin
          e = -1;
          for (int k = 0; k < NUM_REQ; k++) begin
            j = (model_ptr + k) % NUM_REQ;
            if (e < 0 && req_valid[j]) e = j;
          end
          check_value("grant", 64'(req_ready), (e < 0) ? 64'd0 : (64'd1 << e));
          if (e >= 0) begin
            ea = req_a[e*WIDTH +: WIDTH];
            eb = req_b[e*WIDTH +: WIDTH];
            x.id   = ID_W'(e);
            x.prod = stub_mode ? 32'd0 : 32'(ea) * 32'(eb);
            x.err  = stub_mode;
            scb.push_back(x);
            acc_ids.push_back(e);
            model_ptr = (e + 1) % NUM_REQ;
            acc_cyc   = cyc;
            acc_stub  = stub_mode;
          end
        end
        if (sm_start) begin
          n_start++;
          check_value("start_lat", 64'(cyc), 64'(acc_cyc + 1));
        end
        if (resp_valid) begin
          check_value("ready_in_resp", 64'(req_ready), 64'd0);
          if (!prev_rv)
            check_value("resp_lat", 64'(cyc),
                        64'(acc_stub ? acc_cyc + 2 + TIMEOUT : acc_cyc + 3 + LAT));
          if (scb.size() == 0) begin
            check_value("spurious_resp", 64'(resp_valid), 64'd0);
          end else begin
            check_value("resp_id", 64'(resp_id), 64'(scb[0].id));
            check_value("resp_product", 64'(resp_product), 64'(scb[0].prod));
            check_value("resp_err", 64'(resp_err), 64'(scb[0].err));
            if (resp_ready) begin
              x = scb.pop_front();
              got_ids.push_back(int'(resp_id));
              got_prods.push_back(resp_product);
              got_errs.push_back(resp_err);
              hs_cyc = cyc;
            end
          end
        end
        prev_rv = resp_valid;
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  task automatic send(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit done;
    done = 1'b0;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_valid[idx] = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (req_ready[idx]) done = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    check_value("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((scb.size() != 0 || resp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_value("drain", 64'(scb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int exp_ids[5];
    logic [31:0] exp_prods[5];
    int n_acc;
    bit seen;
    exp_ids   = '{0, 1, 2, 3, 0};
    exp_prods = '{32'd3, 32'd6, 32'd9, 32'd12, 32'd3};
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with every requester asking.
    check_value("rst_req_ready", 64'(req_ready), 64'd0);
    check_value("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_value("rst_sm_start", 64'(sm_start), 64'd0);
    check_value("rst_resp_product", 64'(resp_product), 64'd0);
    check_value("rst_resp_id", 64'(resp_id), 64'd0);
    check_value("rst_mcand", 64'(sm_multiplicand), 64'd0);
    req_valid = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All requesters continuously valid: a=i+1, b=3.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      req_b[i*WIDTH +: WIDTH] = 16'd3;
    end
    got_ids.delete();
    got_prods.delete();
    req_valid = '1;
    n_acc = 0;
    for (int t = 0; t < 400 && n_acc < 5; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc == 5) req_valid = '0;
      end
    end
    req_valid = '0;
    drain();
    check_value("rr_count", 64'(got_ids.size()), 64'd5);
    for (int k = 0; k < 5 && k < got_ids.size(); k++) begin
      check_value("rr_id", 64'(got_ids[k]), 64'(exp_ids[k]));
      check_value("rr_prod", 64'(got_prods[k]), 64'(exp_prods[k]));
    end

    // Single request, exactly one start pulse.
    n_start = 0;
    send(0, 16'h1234, 16'h0040);
    drain();
    check_value("single_prod", 64'(got_prods[$]), 64'h0004_8D00);
    check_value("single_id", 64'(got_ids[$]), 64'd0);
    check_value("single_err", 64'(got_errs[$]), 64'd0);
    check_value("single_starts", 64'(n_start), 64'd1);

    // Maximum operands.
    send(2, 16'hFFFF, 16'hFFFF);
    drain();
    check_value("max_prod", 64'(got_prods[$]), 64'hFFFE_0001);
    check_value("max_id", 64'(got_ids[$]), 64'd2);

    // Back-pressure with requester 1 pending.
    resp_ready = 1'b0;
    send(0, 16'd5, 16'd7);
    req_a[1*WIDTH +: WIDTH] = 16'd9;
    req_b[1*WIDTH +: WIDTH] = 16'd11;
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check_value("bp_resp_seen", 64'(seen), 64'd1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check_value("bp_req_ready", 64'(req_ready), 64'd0);
      check_value("bp_hold_valid", 64'(resp_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (req_ready[1]) seen = 1'b1;
    end
    check_value("bp_next_accept", 64'(seen), 64'd1);
    check_value("bp_accept_cycle", 64'(cyc), 64'(hs_cyc + 1));
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain();
    check_value("bp_prod", 64'(got_prods[$]), 64'd99);

    // Watchdog: stubbed SM never completes; next request is normal.
    stub_mode = 1'b1;
    send(3, 16'd100, 16'd100);
    drain();
    check_value("wd_err", 64'(got_errs[$]), 64'd1);
    check_value("wd_prod", 64'(got_prods[$]), 64'd0);
    stub_mode = 1'b0;
    send(3, 16'd2, 16'd5);
    drain();
    check_value("wd_after_prod", 64'(got_prods[$]), 64'd10);
    check_value("wd_after_err", 64'(got_errs[$]), 64'd0);

    // Reset while in WAIT; the pointer has moved to 2 beforehand.
    send(1, 16'd7, 16'd7);
    @(posedge clk);
    req_a[1*WIDTH +: WIDTH] = 16'd3;
    req_b[1*WIDTH +: WIDTH] = 16'd4;
    req_a[3*WIDTH +: WIDTH] = 16'd5;
    req_b[3*WIDTH +: WIDTH] = 16'd6;
    req_valid = 4'b1010;
    #3;
    reset = 1'b1;
    scb.delete();
    got_ids.delete();
    got_prods.delete();
    got_errs.delete();
    acc_ids.delete();
    model_ptr = 0;
    #1;
    check_value("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check_value("mid_rst_sm_start", 64'(sm_start), 64'd0);
    check_value("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check_value("mid_rst_resp_err", 64'(resp_err), 64'd0);
    check_value("mid_rst_resp_id", 64'(resp_id), 64'd0);
    check_value("mid_rst_resp_product", 64'(resp_product), 64'd0);
    check_value("mid_rst_mcand", 64'(sm_multiplicand), 64'd0);
    check_value("mid_rst_mplier", 64'(sm_multiplier), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 400 && n_acc < 2; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        if (n_acc == 0) check_value("post_rst_first_grant", 64'(req_ready), 64'b0010);
        n_acc++;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~req_ready;
      end
    end
    req_valid = '0;
    drain();
    check_value("post_rst_count", 64'(got_ids.size()), 64'd2);
    if (got_ids.size() == 2) begin
      check_value("post_rst_id0", 64'(got_ids[0]), 64'd1);
      check_value("post_rst_prod0", 64'(got_prods[0]), 64'd12);
      check_value("post_rst_id1", 64'(got_ids[1]), 64'd3);
      check_value("post_rst_prod1", 64'(got_prods[1]), 64'd30);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_sm_arbiter
